k16_panel_sequencer: RTL and testbench
======================================

// Module: k16_panel_sequencer
// PURPOSE
//  Front-panel command sequencer between the K16 I/O block and the CPU debug port.
//  - Debounces the panel command/register-select field and fires each accepted
//    command once, over a req/ack handshake to the CPU.
//  - Tracks the panel's current memory address.
//  - Latches results into the address/data LED registers.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000   stable cycles to accept press/release (10 ms @ 25 MHz)
//  ACK_TIMEOUT      1024     WAIT_ACK cycles before abandoning a request
//  REPEAT_CYCLES    6250000  auto-repeat period, only with PANEL_AUTOREPEAT_EN
//  CNT_W            24       shared timer width; must hold the largest parameter
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   synchronous, active-low reset
//  cmd_in       in   4   panel command code (shared command header; NONE = 0)
//  reg_in       in   3   panel register select
//  sw_in        in   16  panel address/data switches
//  fp_req       out  1   command request to CPU
//  fp_cmd       out  4   command being issued
//  fp_reg       out  3   register select being issued
//  fp_addr      out  16  memory address being issued
//  fp_wdata     out  16  deposit data
//  fp_ack       in   1   CPU completion strobe
//  fp_rdata     in   16  CPU read data, valid while fp_ack = 1
//  led_addr     out  16  address LED value
//  led_data     out  16  data LED value
//  busy         out  1   1 in any state other than IDLE
//  timeout_err  out  1   last request timed out
// BEHAVIOUR
//  - Reset: every output 0, cur_addr = 0, state IDLE, timer 0. Reset mid-handshake
//    drops fp_req on that edge.
//  - cmd_in/reg_in pass through 2-flop synchronisers (2-cycle latency); sw_in is
//    sampled directly in ISSUE.
//  - IDLE: synced cmd != NONE -> capture cmd/reg, clear timer, go to DEBOUNCE.
//    fp_ack is ignored here.
//  - DEBOUNCE: cmd differs from the captured value -> IDLE.
//    Timer reaches DEBOUNCE_CYCLES-1 -> ISSUE.
//  - ISSUE (1 cycle): drive fp_cmd/fp_reg and set fp_req = 1 on the exit edge.
//      EXAMINE/DEPOSIT: cur_addr <= sw_in, fp_addr = sw_in.
//      EXAMINE_NEXT/DEPOSIT_NEXT: cur_addr <= cur_addr+1, wrapping 0xFFFF -> 0x0000;
//        fp_addr = the incremented value.
//      START: fp_addr = sw_in; cur_addr unchanged.
//      CONTINUE, INST_STEP, *_REGISTER: fp_addr = cur_addr.
//      DEPOSIT*: fp_wdata = sw_in.
//    Next state: WAIT_ACK.
//  - WAIT_ACK: fp_req and all fp_* outputs held stable.
//    fp_ack = 1 sampled: fp_req = 0 on that same edge; timeout_err <= 0; LED update:
//      memory commands: led_addr <= fp_addr.
//      *_REGISTER: led_addr <= {13'b0, fp_reg}.
//      EXAMINE*: led_data <= fp_rdata.
//      DEPOSIT*: led_data <= fp_wdata.
//      START/CONTINUE/INST_STEP: LEDs unchanged.
//    Timer reaches ACK_TIMEOUT-1 with no ack: fp_req = 0, timeout_err <= 1,
//      LEDs unchanged.
//    Either outcome -> RELEASE.
//  - RELEASE: timer counts while synced cmd == NONE and restarts at 0 otherwise.
//    Reaches DEBOUNCE_CYCLES-1 -> IDLE. A held switch therefore issues exactly once.
//  - fp_req is never re-asserted without passing through ISSUE.
//  - An ack arriving in the same cycle the timeout hits counts as success.
// CONFIGURATION
//  PANEL_AUTOREPEAT_EN defined:
//    - In RELEASE, with the captured cmd one of EXAMINE_NEXT, DEPOSIT_NEXT or
//      INST_STEP still held, a separate counter reaching REPEAT_CYCLES-1 -> ISSUE.
//    - The counter restarts when released.
//  PANEL_AUTOREPEAT_EN undefined:
//    - No repeat counter logic; exactly one issue per press.
// TESTING  (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8, REPEAT_CYCLES=16)
//  1. EXAMINE, sw_in=0x1234, ack after 3 cycles with rdata=0xBEEF -> one fp_req pulse,
//     fp_addr=0x1234, led_addr=0x1234, led_data=0xBEEF, busy=0 after release.
//  2. cur_addr=0xFFFF, DEPOSIT_NEXT, sw_in=0x00AA -> fp_addr=0x0000, fp_wdata=0x00AA,
//     led_data=0x00AA.
//  3. cmd_in toggling NONE/EXAMINE every 2 cycles for 40 cycles -> fp_req never 1.
//  4. EXAMINE with fp_ack tied 0 -> fp_req falls after 8 cycles, timeout_err=1, LEDs
//     unchanged; next acked command clears timeout_err.
//  5. reset_n=0 during WAIT_ACK -> next edge: fp_req=0, busy=0, LEDs=0, cur_addr=0.
//  6. INST_STEP held 80 cycles, immediate acks -> with macro: repeated fp_req pulses
//     16 cycles apart; without macro: exactly one pulse.

Source files
------------

// File: rtl/k16_panel_sequencer.sv
// Front-panel command sequencer: debounces panel commands, issues each over fp_req/fp_ack,
// tracks the panel address and updates the LED registers. Optional macro: PANEL_AUTOREPEAT_EN.
module k16_panel_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ACK_TIMEOUT     = 1024,
  parameter int unsigned REPEAT_CYCLES   = 6250000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  cmd_in,
  input  logic [2:0]  reg_in,
  input  logic [15:0] sw_in,
  output logic        fp_req,
  output logic [3:0]  fp_cmd,
  output logic [2:0]  fp_reg,
  output logic [15:0] fp_addr,
  output logic [15:0] fp_wdata,
  input  logic        fp_ack,
  input  logic [15:0] fp_rdata,
  output logic [15:0] led_addr,
  output logic [15:0] led_data,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_ISSUE, S_WAIT_ACK, S_RELEASE
  } state_t;

  typedef enum logic [3:0] {
    CMD_NONE             = 4'd0,
    CMD_EXAMINE          = 4'd1,
    CMD_EXAMINE_NEXT     = 4'd2,
    CMD_DEPOSIT          = 4'd3,
    CMD_DEPOSIT_NEXT     = 4'd4,
    CMD_START            = 4'd5,
    CMD_CONTINUE         = 4'd6,
    CMD_INST_STEP        = 4'd7,
    CMD_EXAMINE_REGISTER = 4'd8,
    CMD_DEPOSIT_REGISTER = 4'd9
  } cmd_t;

  localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  if (64'(DEBOUNCE_CYCLES) == 64'd0 || 64'(DEBOUNCE_CYCLES) > CNT_RANGE ||
      64'(ACK_TIMEOUT) == 64'd0 || 64'(ACK_TIMEOUT) > CNT_RANGE ||
      64'(REPEAT_CYCLES) < 64'd2 || 64'(REPEAT_CYCLES) > CNT_RANGE) begin : g_cfg_check
    $error("k16_panel_sequencer: timer parameters out of range for CNT_W");
  end

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [3:0]       cmd_s1, cmd_s2, cap_cmd;
  logic [2:0]       reg_s1, reg_s2, cap_reg;
  logic [15:0]      cur_addr;
  logic [15:0]      addr_inc;
  logic             is_mem, is_reg, is_exam, is_dep;
  logic             rpt_fire;

  assign addr_inc = cur_addr + 16'd1;

  always_comb begin
    is_mem  = 1'b0;
    is_reg  = 1'b0;
    is_exam = 1'b0;
    is_dep  = 1'b0;
    case (cap_cmd)
      CMD_EXAMINE, CMD_EXAMINE_NEXT: begin is_mem = 1'b1; is_exam = 1'b1; end
      CMD_DEPOSIT, CMD_DEPOSIT_NEXT: begin is_mem = 1'b1; is_dep  = 1'b1; end
      CMD_EXAMINE_REGISTER:          begin is_reg = 1'b1; is_exam = 1'b1; end
      CMD_DEPOSIT_REGISTER:          begin is_reg = 1'b1; is_dep  = 1'b1; end
      default: ;
    endcase
  end

`ifdef PANEL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_cnt;
  logic             held, is_rpt;

  assign held     = (cmd_s2 == cap_cmd);
  assign is_rpt   = (cap_cmd == CMD_EXAMINE_NEXT) || (cap_cmd == CMD_DEPOSIT_NEXT) ||
                    (cap_cmd == CMD_INST_STEP);
  assign rpt_fire = (state == S_RELEASE) && held && is_rpt && (rpt_cnt == RPT_LAST);

  // Counts cycles since the last issue (the issue cycle itself is 1), so repeats
  // are REPEAT_CYCLES apart regardless of how long the ack took.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
    end else if (state == S_ISSUE) begin
      rpt_cnt <= CNT_W'(1);
    end else if (state == S_WAIT_ACK || state == S_RELEASE) begin
      if (held && is_rpt)
        rpt_cnt <= (rpt_cnt == RPT_LAST) ? rpt_cnt : rpt_cnt + 1'b1;
      else
        rpt_cnt <= '0;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      cmd_s1      <= '0;
      cmd_s2      <= '0;
      reg_s1      <= '0;
      reg_s2      <= '0;
      cap_cmd     <= '0;
      cap_reg     <= '0;
      cur_addr    <= '0;
      fp_req      <= 1'b0;
      fp_cmd      <= '0;
      fp_reg      <= '0;
      fp_addr     <= '0;
      fp_wdata    <= '0;
      led_addr    <= '0;
      led_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_s1 <= cmd_in;
      cmd_s2 <= cmd_s1;
      reg_s1 <= reg_in;
      reg_s2 <= reg_s1;
      case (state)
        S_IDLE: begin
          if (cmd_s2 != CMD_NONE) begin
            cap_cmd <= cmd_s2;
            cap_reg <= reg_s2;
            timer   <= '0;
            busy    <= 1'b1;
            state   <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (cmd_s2 != cap_cmd) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (timer == DEB_LAST) begin
            state <= S_ISSUE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ISSUE: begin
          fp_cmd <= cap_cmd;
          fp_reg <= cap_reg;
          fp_req <= 1'b1;
          timer  <= '0;
          case (cap_cmd)
            CMD_EXAMINE, CMD_DEPOSIT: begin
              cur_addr <= sw_in;
              fp_addr  <= sw_in;
            end
            CMD_EXAMINE_NEXT, CMD_DEPOSIT_NEXT: begin
              cur_addr <= addr_inc;
              fp_addr  <= addr_inc;
            end
            CMD_START: fp_addr <= sw_in;
            default:   fp_addr <= cur_addr;
          endcase
          if (is_dep)
            fp_wdata <= sw_in;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Ack wins over a timeout landing on the same edge.
          if (fp_ack) begin
            fp_req      <= 1'b0;
            timeout_err <= 1'b0;
            if (is_mem)  led_addr <= fp_addr;
            if (is_reg)  led_addr <= {13'b0, fp_reg};
            if (is_exam) led_data <= fp_rdata;
            if (is_dep)  led_data <= fp_wdata;
            timer <= '0;
            state <= S_RELEASE;
          end else if (timer == ACK_LAST) begin
            fp_req      <= 1'b0;
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= S_RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RELEASE: begin
          if (rpt_fire) begin
            state <= S_ISSUE;
          end else if (cmd_s2 != CMD_NONE) begin
            timer <= '0;
          end else if (timer == DEB_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k16_panel_sequencer.sv
// Bench for k16_panel_sequencer: cycle-level behavioural model with per-cycle compare,
// directed panel scenarios and randomized presses, glitches, acks and resets.
module tb_k16_panel_sequencer;
  localparam int DEB  = 4;
  localparam int ACKT = 8;
  localparam int RPT  = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  cmd_in = '0;
  logic [2:0]  reg_in = '0;
  logic [15:0] sw_in = '0;
  logic        fp_req;
  logic [3:0]  fp_cmd;
  logic [2:0]  fp_reg;
  logic [15:0] fp_addr, fp_wdata;
  logic        fp_ack = 1'b0;
  logic [15:0] fp_rdata = '0;
  logic [15:0] led_addr, led_data;
  logic        busy, timeout_err;

  always #5 clk = ~clk;

  k16_panel_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .ACK_TIMEOUT    (ACKT),
    .REPEAT_CYCLES  (RPT),
    .CNT_W          (24)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_in(cmd_in), .reg_in(reg_in), .sw_in(sw_in),
    .fp_req(fp_req), .fp_cmd(fp_cmd), .fp_reg(fp_reg), .fp_addr(fp_addr),
    .fp_wdata(fp_wdata), .fp_ack(fp_ack), .fp_rdata(fp_rdata),
    .led_addr(led_addr), .led_data(led_data), .busy(busy), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {PH_IDLE, PH_SETTLE, PH_ISSUE, PH_AWAIT, PH_RELEASE} ph_t;
  ph_t ph = PH_IDLE;
  int  m_c1 = 0, m_c2 = 0, m_r1 = 0, m_r2 = 0;
  int  n = 0, cap = 0, capr = 0, cur = 0, rpt = 0;
  int  e_req = 0, e_cmd = 0, e_reg = 0, e_addr = 0, e_wdata = 0;
  int  e_la = 0, e_ld = 0, e_busy = 0, e_to = 0;
  int  sc, sr;
  bit  fire;

  function automatic bit c_exam(int c); return c == 1 || c == 2 || c == 8; endfunction
  function automatic bit c_dep(int c);  return c == 3 || c == 4 || c == 9; endfunction
  function automatic bit c_mem(int c);  return c >= 1 && c <= 4; endfunction
  function automatic bit c_regc(int c); return c == 8 || c == 9; endfunction
  function automatic bit c_rep(int c);  return c == 2 || c == 4 || c == 7; endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_c1 = 0; m_c2 = 0; m_r1 = 0; m_r2 = 0;
      ph = PH_IDLE; n = 0; cap = 0; capr = 0; cur = 0; rpt = 0;
      e_req = 0; e_cmd = 0; e_reg = 0; e_addr = 0; e_wdata = 0;
      e_la = 0; e_ld = 0; e_busy = 0; e_to = 0;
    end else begin
      sc = m_c2; sr = m_r2;
      m_c2 = m_c1; m_c1 = int'(cmd_in);
      m_r2 = m_r1; m_r1 = int'(reg_in);
      case (ph)
        PH_IDLE: if (sc != 0) begin
          cap = sc; capr = sr; n = 0; e_busy = 1; ph = PH_SETTLE;
        end
        PH_SETTLE: begin
          if (sc != cap) begin e_busy = 0; ph = PH_IDLE; end
          else begin n++; if (n == DEB) ph = PH_ISSUE; end
        end
        PH_ISSUE: begin
          e_cmd = cap; e_reg = capr; e_req = 1; n = 0; rpt = 1;
          if (cap == 1 || cap == 3) begin cur = int'(sw_in); e_addr = cur; end
          else if (cap == 2 || cap == 4) begin cur = (cur + 1) % 65536; e_addr = cur; end
          else if (cap == 5) e_addr = int'(sw_in);
          else e_addr = cur;
          if (c_dep(cap)) e_wdata = int'(sw_in);
          ph = PH_AWAIT;
        end
        PH_AWAIT: begin
          if (sc == cap && c_rep(cap)) rpt = (rpt < RPT - 1) ? rpt + 1 : rpt;
          else rpt = 0;
          if (fp_ack) begin
            e_req = 0; e_to = 0;
            if (c_mem(cap))  e_la = e_addr;
            if (c_regc(cap)) e_la = e_reg;
            if (c_exam(cap)) e_ld = int'(fp_rdata);
            if (c_dep(cap))  e_ld = e_wdata;
            n = 0; ph = PH_RELEASE;
          end else begin
            n++;
            if (n == ACKT) begin e_req = 0; e_to = 1; n = 0; ph = PH_RELEASE; end
          end
        end
        PH_RELEASE: begin
          fire = 1'b0;
`ifdef PANEL_AUTOREPEAT_EN
          if (sc == cap && c_rep(cap)) begin
            if (rpt == RPT - 1) fire = 1'b1;
            else rpt++;
          end else rpt = 0;
`endif
          if (fire) ph = PH_ISSUE;
          else if (sc != 0) n = 0;
          else begin
            n++;
            if (n == DEB) begin e_busy = 0; ph = PH_IDLE; end
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("fp_req",      32'(fp_req),      32'(e_req));
    chk("fp_cmd",      32'(fp_cmd),      32'(e_cmd));
    chk("fp_reg",      32'(fp_reg),      32'(e_reg));
    chk("fp_addr",     32'(fp_addr),     32'(e_addr));
    chk("fp_wdata",    32'(fp_wdata),    32'(e_wdata));
    chk("led_addr",    32'(led_addr),    32'(e_la));
    chk("led_data",    32'(led_data),    32'(e_ld));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
  end

  // ---------------- CPU-side responder ----------------
  int          ack_delay = 0;
  int          wcnt = 0;
  bit          spurious = 1'b0;
  bit          rand_rdata = 1'b1;
  logic [15:0] fixed_rdata = 16'hBEEF;

  always @(negedge clk) begin
    fp_rdata = rand_rdata ? 16'($urandom) : fixed_rdata;
    if (fp_req === 1'b1 && !fp_ack) begin
      if (ack_delay >= 0 && wcnt >= ack_delay) fp_ack = 1'b1;
      else begin fp_ack = 1'b0; wcnt++; end
    end else begin
      fp_ack = (fp_req !== 1'b1) && spurious && ($urandom_range(0, 7) == 0);
      wcnt = 0;
    end
  end

  // ---------------- fp_req pulse monitor ----------------
  int   cyc = 0, pulse_cnt = 0, cur_len = 0, last_len = 0;
  int   ptimes[$];
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (fp_req === 1'b1) begin
      if (!prev_req) begin pulse_cnt++; ptimes.push_back(cyc); cur_len = 0; end
      cur_len++;
    end else if (prev_req) begin
      last_len = cur_len;
    end
    prev_req = (fp_req === 1'b1);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c, input logic [2:0] r, input logic [15:0] sw,
                       input int hold);
    cmd_in = c; reg_in = r; sw_in = sw;
    tick(hold);
    cmd_in = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(1); k++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, k;
    tick(3);
    chk("rst_fp_req",   32'(fp_req),      32'd0);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_led_addr", 32'(led_addr),    32'd0);
    chk("rst_led_data", 32'(led_data),    32'd0);
    chk("rst_timeout",  32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // 1: EXAMINE 0x1234, ack three cycles after request
    rand_rdata = 1'b0; fixed_rdata = 16'hBEEF; ack_delay = 3;
    p0 = pulse_cnt;
    press(4'd1, 3'd0, 16'h1234, 18);
    wait_idle("t1_idle", 60);
    chk("t1_pulses",   32'(pulse_cnt - p0), 32'd1);
    chk("t1_req_len",  32'(last_len),       32'd4);
    chk("t1_fp_addr",  32'(fp_addr),        32'h1234);
    chk("t1_led_addr", 32'(led_addr),       32'h1234);
    chk("t1_led_data", 32'(led_data),       32'hBEEF);
    chk("t1_model_la", 32'(e_la),           32'h1234);

    // 2: DEPOSIT_NEXT wraps 0xFFFF -> 0x0000
    ack_delay = 0;
    press(4'd1, 3'd0, 16'hFFFF, 18);
    wait_idle("t2a_idle", 60);
    press(4'd4, 3'd0, 16'h00AA, 18);
    wait_idle("t2_idle", 60);
    chk("t2_fp_cmd",   32'(fp_cmd),   32'd4);
    chk("t2_fp_addr",  32'(fp_addr),  32'h0000);
    chk("t2_fp_wdata", 32'(fp_wdata), 32'h00AA);
    chk("t2_led_data", 32'(led_data), 32'h00AA);
    chk("t2_led_addr", 32'(led_addr), 32'h0000);
    chk("t2_model_ld", 32'(e_ld),     32'h00AA);

    // 3: bouncing contact never issues
    p0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      cmd_in = (i % 2 == 1) ? 4'd1 : 4'd0;
      tick(2);
    end
    cmd_in = '0;
    tick(10);
    chk("t3_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("t3_busy",   32'(busy),           32'd0);

    // 4: no ack -> timeout, LEDs kept; next acked command clears the error
    ack_delay = -1;
    press(4'd1, 3'd0, 16'h5555, 22);
    wait_idle("t4_idle", 60);
    chk("t4_timeout",  32'(timeout_err), 32'd1);
    chk("t4_req_len",  32'(last_len),    32'd8);
    chk("t4_fp_addr",  32'(fp_addr),     32'h5555);
    chk("t4_led_addr", 32'(led_addr),    32'h0000);
    chk("t4_led_data", 32'(led_data),    32'h00AA);
    ack_delay = 2;
    press(4'd2, 3'd0, 16'h0000, 20);
    wait_idle("t4b_idle", 60);
    chk("t4b_timeout",  32'(timeout_err), 32'd0);
    chk("t4b_led_addr", 32'(led_addr),    32'h5556);
    chk("t4b_led_data", 32'(led_data),    32'hBEEF);

    // 5: reset in the middle of a handshake
    ack_delay = -1;
    cmd_in = 4'd1; sw_in = 16'h4321;
    k = 0;
    while (fp_req !== 1'b1 && k < 40) begin tick(1); k++; end
    chk("t5_req_rise", 32'(fp_req), 32'd1);
    tick(2);
    reset_n = 1'b0; cmd_in = '0;
    tick(1);
    chk("t5_fp_req",   32'(fp_req),      32'd0);
    chk("t5_busy",     32'(busy),        32'd0);
    chk("t5_led_addr", 32'(led_addr),    32'd0);
    chk("t5_led_data", 32'(led_data),    32'd0);
    chk("t5_fp_addr",  32'(fp_addr),     32'd0);
    reset_n = 1'b1;
    tick(2);
    ack_delay = 0;
    press(4'd2, 3'd0, 16'h0000, 18);
    wait_idle("t5b_idle", 60);
    chk("t5b_fp_addr",  32'(fp_addr),  32'h0001);
    chk("t5b_led_addr", 32'(led_addr), 32'h0001);

    // 6: INST_STEP held for 80 cycles with immediate acks
    ack_delay = 0;
    ptimes.delete();
    p0 = pulse_cnt;
    press(4'd7, 3'd3, 16'h0000, 80);
    wait_idle("t6_idle", 100);
    chk("t6_led_addr", 32'(led_addr), 32'h0001);
`ifdef PANEL_AUTOREPEAT_EN
    chk("t6_many_pulses", 32'(pulse_cnt - p0 >= 4), 32'd1);
    for (int i = 1; i < ptimes.size(); i++)
      chk("t6_period", 32'(ptimes[i] - ptimes[i-1]), 32'(RPT));
`else
    chk("t6_pulses", 32'(pulse_cnt - p0), 32'd1);
`endif

    // Randomized presses, glitches, ack latencies, spurious acks and resets
    spurious = 1'b1; rand_rdata = 1'b1;
    for (int s = 0; s < 250; s++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        reset_n = 1'b0;
        tick(int'($urandom_range(1, 2)));
        reset_n = 1'b1;
      end else begin
        if (r < 45)      cmd_in = '0;
        else if (r < 88) cmd_in = 4'($urandom_range(1, 9));
        else             cmd_in = 4'($urandom_range(10, 15));
        reg_in = 3'($urandom);
        sw_in  = 16'($urandom);
        ack_delay = int'($urandom_range(0, 11));
        if (ack_delay > 9) ack_delay = -1;
        tick(int'($urandom_range(1, 24)));
      end
    end
    cmd_in = '0; spurious = 1'b0; ack_delay = 0;
    tick(30);
    chk("end_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
